// File: rtl/tagger_pkg.sv
// Shared definitions for the tagger record path: widths, entry layout and serializer states.
package tagger_pkg;

  localparam int unsigned RECORD_W         = 47;
  localparam int unsigned WORD_W           = 16;
  localparam int unsigned WORDS_PER_RECORD = 3;
  localparam int unsigned ENTRY_W          = WORD_W * WORDS_PER_RECORD;

  // Bit positions inside a stored 48-bit entry
  localparam int unsigned LOSS_BIT = 47;
  localparam int unsigned WRAP_BIT = 46;
  localparam int unsigned TYPE_BIT = 45;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } ser_state_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic loss,
                                                    input logic [RECORD_W-1:0] rec);
    return {loss, rec};
  endfunction

endpackage

// File: rtl/record_fifo.sv
// Single-clock FIFO with fall-through read and occupancy count.
module record_fifo
  import tagger_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = ENTRY_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [(1 << DEPTH_LOG2)];
  logic [DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/record_serializer.sv
// Buffers 47-bit tag records and emits each as three 16-bit words over valid/ack,
// tracking dropped records in a counter and as an in-band loss flag.
module record_serializer
  import tagger_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned LOST_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RECORD_W-1:0]   record_data,
  input  logic                  record_ready,
  output logic [WORD_W-1:0]     word_data,
  output logic                  word_valid,
  input  logic                  word_ack,
  input  logic                  clear_overflow,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [LOST_W-1:0]     lost_count,
  output logic                  overflow
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  ser_state_e           state_q, state_d;
  logic [ENTRY_W-1:0]   shreg_q, shreg_d, fifo_rd;
  logic                 valid_q, valid_d;
  logic                 pending_q, pending_d;
  logic [LOST_W-1:0]    lost_q, lost_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push, drop, pop;

  // Full test uses the registered count, so a same-cycle pop never frees a slot for a write
  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);
  assign push  = record_ready && !full;
  assign drop  = record_ready && full;

  record_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .data_i  (make_entry(pending_q, record_data)),
    .pop_i   (pop),
    .data_o  (fifo_rd),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = W0;
      end
      W0: if (word_ack) state_d = W1;
      W1: if (word_ack) state_d = W2;
      W2: if (word_ack) begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = W0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Presented word is always the low slice; each ack shifts the next slice down
  always_comb begin
    shreg_d = shreg_q;
    if (pop)
      shreg_d = fifo_rd;
    else if (state_q != IDLE && word_ack)
      shreg_d = shreg_q >> WORD_W;
    valid_d = (state_d != IDLE);
  end

  always_comb begin
    pending_d = pending_q;
    lost_d    = lost_q;
    ovf_d     = ovf_q;
    if (drop)      pending_d = 1'b1;
    else if (push) pending_d = 1'b0;
    if (clear_overflow) begin
      lost_d = '0;
      ovf_d  = 1'b0;
    end
    if (drop) begin
      if (lost_d != '1) lost_d = lost_d + 1'b1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      lost_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      ovf_q     <= ovf_d;
    end
  end

  assign word_data  = shreg_q[WORD_W-1:0];
  assign word_valid = valid_q;
  assign lost_count = lost_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_record_serializer.sv
// Randomized and directed bench for record_serializer against a queue-based reference model.
module tb_record_serializer;

  localparam int unsigned DL    = 2;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [46:0]   record_data = '0;
  logic          record_ready = 1'b0;
  logic [15:0]   word_data;
  logic          word_valid;
  logic          word_ack = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [DL:0]   fifo_count;
  logic [LW-1:0] lost_count;
  logic          overflow;

  record_serializer #(.DEPTH_LOG2(DL), .LOST_W(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .record_data    (record_data),
    .record_ready   (record_ready),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ack       (word_ack),
    .clear_overflow (clear_overflow),
    .fifo_count     (fifo_count),
    .lost_count     (lost_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stored entries, words still to deliver for the current record
  logic [47:0] mq[$];
  logic [15:0] mw[$];
  int unsigned m_lost;
  bit          m_ovf, m_pend;

  function automatic void model_reset();
    mq.delete();
    mw.delete();
    m_lost = 0;
    m_ovf  = 0;
    m_pend = 0;
  endfunction

  task automatic model_edge(input bit rdy, input logic [46:0] d, input bit ack, input bit clr);
    bit full, drop;
    logic [47:0] e;
    full = (mq.size() == DEPTH);
    drop = rdy && full;
    if (mw.size() > 0 && ack) void'(mw.pop_front());
    if (mw.size() == 0 && mq.size() > 0) begin
      e = mq.pop_front();
      mw.push_back(e[15:0]);
      mw.push_back(e[31:16]);
      mw.push_back(e[47:32]);
    end
    if (rdy && !full) begin
      mq.push_back({m_pend, d});
      m_pend = 0;
    end
    if (drop) m_pend = 1;
    if (clr) begin
      m_lost = 0;
      m_ovf  = 0;
    end
    if (drop) begin
      if (m_lost != (1 << LW) - 1) m_lost++;
      m_ovf = 1;
    end
  endtask

  task automatic model_check();
    check("valid", {63'd0, word_valid}, {63'd0, mw.size() > 0});
    if (mw.size() > 0) check("word", {48'd0, word_data}, {48'd0, mw[0]});
    check("count", {61'd0, fifo_count}, 64'(mq.size()));
    check("lost", {48'd0, lost_count}, 64'(m_lost));
    check("ovf", {63'd0, overflow}, {63'd0, m_ovf});
  endtask

  // Called at a negedge: drive, clock once, update model, compare at next negedge
  task automatic step(input bit rdy, input logic [46:0] d, input bit ack, input bit clr);
    record_ready   = rdy;
    record_data    = d;
    word_ack       = ack;
    clear_overflow = clr;
    @(posedge clk);
    model_edge(rdy, d, ack, clr);
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input bit ack, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, '0, ack, 0);
  endtask

  function automatic logic [46:0] rnd_rec();
    return 47'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [46:0] r;
    int unsigned run, max_run;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, word_valid}, 64'd0);
    check("rst_word", {48'd0, word_data}, 64'd0);
    check("rst_count", {61'd0, fifo_count}, 64'd0);
    check("rst_lost", {48'd0, lost_count}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single record, ack held high
    r = 47'h5234_5678_9ABC;
    step(1, r, 1, 0);
    check("lat_count", {61'd0, fifo_count}, 64'd1);
    step(0, '0, 1, 0);
    check("w0", {47'd0, word_valid, word_data}, {47'd0, 1'b1, 16'h9ABC});
    step(0, '0, 1, 0);
    check("w1", {48'd0, word_data}, 64'h5678);
    step(0, '0, 1, 0);
    check("w2", {48'd0, word_data}, 64'h5234);
    check("w2_loss", {63'd0, word_data[15]}, 64'd0);
    step(0, '0, 1, 0);
    check("single_done", {60'd0, word_valid, fifo_count}, 64'd0);

    // Ack stall during W1
    r = rnd_rec();
    step(1, r, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      step(0, '0, 0, 0);
      check("stall_w1", {47'd0, word_valid, word_data}, {47'd0, 1'b1, r[31:16]});
    end
    step(0, '0, 1, 0);
    check("stall_w2", {48'd0, word_data}, {48'd0, 1'b0, r[46:32]});
    idle(1, 2);

    // Overflow: 7 strobes with ack low
    for (int unsigned i = 0; i < 7; i++) step(1, rnd_rec(), 0, 0);
    check("ovf_count", {61'd0, fifo_count}, 64'd4);
    check("ovf_lost", {48'd0, lost_count}, 64'd2);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    idle(1, 20);
    step(1, rnd_rec(), 1, 0);
    idle(1, 3);
    check("loss_flag_set", {63'd0, word_data[15]}, 64'd1);
    idle(1, 1);
    step(1, rnd_rec(), 1, 0);
    idle(1, 3);
    check("loss_flag_clr", {63'd0, word_data[15]}, 64'd0);
    idle(1, 1);

    // Back-to-back: three records, ack high
    run = 0;
    max_run = 0;
    for (int unsigned i = 0; i < 15; i++) begin
      step(i < 3, rnd_rec(), 1, 0);
      run = word_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    check("b2b_run", 64'(max_run), 64'd9);

    // Clear coinciding with a drop, then clear alone
    for (int unsigned i = 0; i < 5; i++) step(1, rnd_rec(), 0, 0);
    check("full_count", {61'd0, fifo_count}, 64'd4);
    step(1, rnd_rec(), 0, 1);
    check("clr_drop_lost", {48'd0, lost_count}, 64'd1);
    check("clr_drop_ovf", {63'd0, overflow}, 64'd1);
    step(0, '0, 0, 1);
    check("clr_lost", {48'd0, lost_count}, 64'd0);
    check("clr_ovf", {63'd0, overflow}, 64'd0);
    idle(1, 20);

    // Random traffic
    for (int unsigned i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 4, rnd_rec(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0);
    idle(1, 20);

    // Reset mid-record with three records queued
    for (int unsigned i = 0; i < 4; i++) step(1, rnd_rec(), 0, 0);
    step(0, '0, 1, 0);
    check("pre_rst_count", {61'd0, fifo_count}, 64'd3);
    word_ack = 1'b1;
    reset = 1'b1;
    #1;
    check("async_valid", {63'd0, word_valid}, 64'd0);
    check("async_word", {48'd0, word_data}, 64'd0);
    check("async_count", {61'd0, fifo_count}, 64'd0);
    check("async_lost", {48'd0, lost_count}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(1, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
